// File: rtl/rsa_modexp_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rsa_modexp_engine : result = msg^exp mod modulus, right-to-left square-and-
//                     multiply over a bit-serial interleaved modular multiplier
// Revision 1.0
// ============================================================================
module rsa_modexp_engine #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     msg,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     modulus,
    input  logic                 abort,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_SELECT = 3'd2,
        S_MUL_R  = 3'd3,
        S_MUL_B  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     mod_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [WIDTH-1:0]     base_q;
    logic [WIDTH-1:0]     res_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     result_q;
    logic                 err_q;
    logic                 out_valid_q;

    logic [WIDTH:0]       w_n_ext;
    logic [WIDTH:0]       w_dbl;
    logic [WIDTH:0]       w_dbl_red;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     acc_d;
    logic                 w_last;

    // One interleaved step: acc = (2*acc + bit*a) mod n, on a WIDTH+1 bit path
    always_comb begin
        w_n_ext   = {1'b0, mod_q};
        w_dbl     = {acc_q, 1'b0};
        w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
        w_sum     = w_dbl_red + (mul_b_q[WIDTH-1] ? {1'b0, mul_a_q} : '0);
        acc_d     = (w_sum >= w_n_ext) ? WIDTH'(w_sum - w_n_ext) : w_sum[WIDTH-1:0];
    end

    assign w_last    = (cnt_q == CNT_W'(WIDTH - 1));
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = !in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mod_q       <= '0;
            exp_q       <= '0;
            base_q      <= '0;
            res_q       <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (state_q != S_IDLE && abort) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (modulus < WIDTH'(2)) begin
                            state_q     <= S_DONE;
                            err_q       <= 1'b1;
                            result_q    <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            // The accept edge performs the first reduction step
                            // directly: with acc=0 and a=1 it yields msg's MSB.
                            mod_q   <= modulus;
                            exp_q   <= exp;
                            mul_a_q <= WIDTH'(1);
                            acc_q   <= {{(WIDTH-1){1'b0}}, msg[WIDTH-1]};
                            mul_b_q <= {msg[WIDTH-2:0], 1'b0};
                            cnt_q   <= CNT_W'(1);
                            state_q <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE, S_MUL_R, S_MUL_B: begin
                    acc_q   <= acc_d;
                    mul_b_q <= {mul_b_q[WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (w_last) begin
                        if (state_q == S_REDUCE) begin
                            base_q  <= acc_d;
                            res_q   <= WIDTH'(1);
                            state_q <= S_SELECT;
                        end else if (state_q == S_MUL_R) begin
                            res_q <= acc_d;
                            // No squaring needed when no exponent bits remain
                            if (exp_q[EXP_WIDTH-1:1] == '0) begin
                                result_q    <= acc_d;
                                out_valid_q <= 1'b1;
                                exp_q       <= exp_q >> 1;
                                state_q     <= S_DONE;
                            end else begin
                                acc_q   <= '0;
                                cnt_q   <= '0;
                                mul_a_q <= base_q;
                                mul_b_q <= base_q;
                                state_q <= S_MUL_B;
                            end
                        end else begin
                            base_q  <= acc_d;
                            exp_q   <= exp_q >> 1;
                            state_q <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (exp_q == '0) begin
                        result_q    <= res_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        mul_b_q <= base_q;
                        mul_a_q <= exp_q[0] ? res_q : base_q;
                        state_q <= exp_q[0] ? S_MUL_R : S_MUL_B;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        result_q    <= '0;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_rsa_modexp_engine : directed and randomized checks against a modexp model
// Revision 1.0
// ============================================================================
module tb_rsa_modexp_engine;

    localparam int W  = 16;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  msg = '0;
    logic [EW-1:0] exp_v = '0;
    logic [W-1:0]  modulus = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rsa_modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg       (msg),
        .exp       (exp_v),
        .modulus   (modulus),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic longint ref_modexp(longint m, longint e, longint n);
        longint r, b;
        r = 1;
        b = m % n;
        while (e > 0) begin
            if (e % 2 == 1) r = (r * b) % n;
            b = (b * b) % n;
            e = e / 2;
        end
        return r % n;
    endfunction

    function automatic int ref_lat(longint e, longint n);
        int l, p;
        if (n < 2) return 1;
        if (e == 0) return W + 1;
        l = 0;
        p = 0;
        for (int i = 0; i < EW; i++) begin
            if (((e >> i) & 1) == 1) begin
                p++;
                l = i + 1;
            end
        end
        return W + l + W * (p + l - 1);
    endfunction

    // Reference: an operation is a count of edges since acceptance
    bit     m_active = 1'b0;
    int     m_cnt = 0;
    int     m_lat = 0;
    longint m_res = 0;
    bit     m_err = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_lat    = ref_lat(longint'(exp_v), longint'(modulus));
                m_err    = (modulus < 2);
                m_res    = m_err ? 0 : ref_modexp(longint'(msg), longint'(exp_v), longint'(modulus));
            end
        end else if (m_cnt >= m_lat - 1) begin
            if (out_ready || abort) m_active = 1'b0;
        end else if (abort) begin
            m_active = 1'b0;
        end else begin
            m_cnt++;
        end
    end

    always @(negedge clk) begin
        bit v;
        v = m_active && (m_cnt >= m_lat - 1);
        check("in_ready", in_ready, !m_active);
        check("busy", busy, m_active);
        check("out_valid", out_valid, v);
        check("err", err, v && m_err);
        check("result", result, v ? m_res : 0);
    end

    // Presents one operand set; returns at the first sample after acceptance
    task automatic start(input longint m, input longint e, input longint n);
        @(negedge clk);
        msg      = W'(m);
        exp_v    = EW'(e);
        modulus  = W'(n);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(input string nm, input longint m, input longint e, input longint n,
                       input longint res, input bit e_err, input int lat);
        int c;
        out_ready = 1'b1;
        start(m, e, n);
        wait_valid(c);
        check({nm, "_lat"}, c, lat);
        check({nm, "_result"}, result, res);
        check({nm, "_err"}, err, e_err);
        @(negedge clk);
        check({nm, "_idle"}, in_ready, 1);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run("m4e13", 4, 13, 497, 445, 0, 116);
        run("m600", 600, 1, 497, 103, 0, 33);
        run("fullw", 65534, 2, 65521, 169, 0, 50);
        run("e0", 1234, 0, 497, 1, 0, 17);
        run("n1", 5, 3, 1, 0, 1, 1);
        run("n0", 5, 3, 0, 0, 1, 1);

        // Back-pressure with a second operand set waiting
        out_ready = 1'b0;
        start(4, 13, 497);
        wait_valid(c);
        check("bp_lat", c, 116);
        msg = 16'd3; exp_v = 16'd5; modulus = 16'd7; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_result", result, 445);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(c);
        check("bp2_lat", c, 83);
        check("bp2_result", result, 5);
        out_ready = 1'b1;
        @(negedge clk);

        // Abort mid-run
        start(4, 13, 497);
        repeat (39) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (150) @(negedge clk);
        run("after_abort", 3, 5, 7, 5, 0, 83);

        // Abort coinciding with the output handshake
        out_ready = 1'b0;
        start(3, 5, 7);
        wait_valid(c);
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_hs_in_ready", in_ready, 1);
        check("abort_hs_valid", out_valid, 0);

        // Asynchronous reset in the middle of a squaring
        start(4, 13, 497);
        repeat (39) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run("after_rst", 4, 13, 497, 445, 0, 116);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 7) != 0);
            msg      = W'($urandom);
            case ($urandom_range(0, 9))
                0:       modulus = W'($urandom_range(0, 1));
                1:       modulus = W'(16'hFFF0 + $urandom_range(0, 15));
                default: modulus = W'($urandom);
            endcase
            exp_v     = EW'($urandom & ((32'd1 << $urandom_range(0, EW)) - 32'd1));
            out_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (600) @(negedge clk);
        check("final_idle", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
